// File: rtl/synapse_access_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// synapse_access_ctrl : load / spike lookup / kill dump controller for one
//                       single-port synapse weight BRAM.      Rev 1.0
// ---------------------------------------------------------------------------
module synapse_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_weight_i,
  output logic              load_done_o,
  input  logic              kill_i,
  input  logic              spike_valid_i,
  output logic              spike_ready_o,
  input  logic [ADDR_W-1:0] spike_id_i,
  output logic              w_out_valid_o,
  input  logic              w_out_ready_i,
  output logic [DATA_W-1:0] w_out_o,
  output logic [ADDR_W-1:0] w_out_id_o,
  output logic              w_out_last_o,
  output logic              dump_active_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [DATA_W-1:0] bram_data_o,
  output logic              bram_w_en_o,
  input  logic [DATA_W-1:0] bram_q_i
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RD_ISSUE = 3'd2,
    RD_CAPT  = 3'd3,
    OUT_HOLD = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_data_q, bram_data_d;
  logic              bram_w_en_q, bram_w_en_d;
  logic              load_done_q, load_done_d;
  logic [DATA_W-1:0] w_out_q, w_out_d;
  logic [ADDR_W-1:0] w_out_id_q, w_out_id_d;
  logic              w_out_valid_q, w_out_valid_d;
  logic              w_out_last_q, w_out_last_d;
  logic              kill_pend_q, kill_pend_d;
  logic              dump_q, dump_d;
  logic              issue_wait_q, issue_wait_d;
  logic              spike_ready;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    bram_addr_d   = bram_addr_q;
    bram_data_d   = bram_data_q;
    bram_w_en_d   = 1'b0;
    w_out_d       = w_out_q;
    w_out_id_d    = w_out_id_q;
    w_out_valid_d = w_out_valid_q;
    w_out_last_d  = w_out_last_q;
    kill_pend_d   = kill_pend_q;
    dump_d        = dump_q;
    issue_wait_d  = issue_wait_q;
    in_ready_o    = 1'b0;
    spike_ready   = 1'b0;
    // Pulse follows the cycle in which the final table write is on the port.
    load_done_d   = bram_w_en_q && (bram_addr_q == LAST_ADDR);

    if (kill_i && !dump_q) begin
      kill_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (load_start_i) begin
          wr_ptr_d = '0;
          state_d  = LOAD;
        end else if (kill_pend_q || kill_i) begin
          dump_d       = 1'b1;
          bram_addr_d  = '0;
          issue_wait_d = 1'b0;
          state_d      = RD_ISSUE;
        end else begin
          spike_ready = !w_out_valid_q;
          if (spike_valid_i && !w_out_valid_q) begin
            bram_addr_d  = spike_id_i;
            issue_wait_d = 1'b0;
            state_d      = RD_ISSUE;
          end
        end
      end

      LOAD: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          bram_addr_d = wr_ptr_q;
          bram_data_d = in_weight_i;
          bram_w_en_d = 1'b1;
          if (wr_ptr_q == LAST_ADDR) begin
            wr_ptr_d = '0;
            state_d  = IDLE;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end

      // Two issue cycles: the BRAM clocks the address, then presents q.
      RD_ISSUE: begin
        issue_wait_d = 1'b1;
        if (issue_wait_q) begin
          issue_wait_d = 1'b0;
          state_d      = RD_CAPT;
        end
      end

      RD_CAPT: begin
        w_out_d       = bram_q_i;
        w_out_id_d    = bram_addr_q;
        w_out_valid_d = 1'b1;
        w_out_last_d  = dump_q && (bram_addr_q == LAST_ADDR);
        state_d       = OUT_HOLD;
      end

      OUT_HOLD: begin
        if (w_out_ready_i) begin
          w_out_valid_d = 1'b0;
          w_out_last_d  = 1'b0;
          if (dump_q && (bram_addr_q != LAST_ADDR)) begin
            bram_addr_d  = bram_addr_q + 1'b1;
            issue_wait_d = 1'b0;
            state_d      = RD_ISSUE;
          end else begin
            if (dump_q) begin
              dump_d      = 1'b0;
              kill_pend_d = 1'b0;
            end
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      bram_addr_q   <= '0;
      bram_data_q   <= '0;
      bram_w_en_q   <= 1'b0;
      load_done_q   <= 1'b0;
      w_out_q       <= '0;
      w_out_id_q    <= '0;
      w_out_valid_q <= 1'b0;
      w_out_last_q  <= 1'b0;
      kill_pend_q   <= 1'b0;
      dump_q        <= 1'b0;
      issue_wait_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      bram_addr_q   <= bram_addr_d;
      bram_data_q   <= bram_data_d;
      bram_w_en_q   <= bram_w_en_d;
      load_done_q   <= load_done_d;
      w_out_q       <= w_out_d;
      w_out_id_q    <= w_out_id_d;
      w_out_valid_q <= w_out_valid_d;
      w_out_last_q  <= w_out_last_d;
      kill_pend_q   <= kill_pend_d;
      dump_q        <= dump_d;
      issue_wait_q  <= issue_wait_d;
    end
  end

  // Held low during reset so every output reads 0 while rst_n is asserted.
  assign spike_ready_o = rst_n & spike_ready;
  assign load_done_o   = load_done_q;
  assign w_out_valid_o = w_out_valid_q;
  assign w_out_o       = w_out_q;
  assign w_out_id_o    = w_out_id_q;
  assign w_out_last_o  = w_out_last_q;
  assign dump_active_o = dump_q;
  assign bram_addr_o   = bram_addr_q;
  assign bram_data_o   = bram_data_q;
  assign bram_w_en_o   = bram_w_en_q;

endmodule
`default_nettype wire

// File: tb/tb_synapse_access_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_synapse_access_ctrl : randomized bench with BRAM model and reference table.
// ---------------------------------------------------------------------------
module tb_synapse_access_ctrl;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_start = 1'b0, in_valid = 1'b0, kill = 1'b0;
  logic              spike_valid = 1'b0, w_out_ready = 1'b0;
  logic [DATA_W-1:0] in_weight = '0;
  logic [ADDR_W-1:0] spike_id = '0;
  logic              in_ready, load_done, spike_ready, w_out_valid, w_out_last;
  logic              dump_active, bram_w_en;
  logic [DATA_W-1:0] w_out, bram_data, bram_q;
  logic [ADDR_W-1:0] w_out_id, bram_addr;

  logic [DATA_W-1:0] bram_mem [DEPTH];
  logic [DATA_W-1:0] ref_mem  [DEPTH];
  int n_vec = 0;
  int n_err = 0;

  synapse_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start_i(load_start), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_weight_i(in_weight), .load_done_o(load_done), .kill_i(kill),
    .spike_valid_i(spike_valid), .spike_ready_o(spike_ready), .spike_id_i(spike_id),
    .w_out_valid_o(w_out_valid), .w_out_ready_i(w_out_ready), .w_out_o(w_out),
    .w_out_id_o(w_out_id), .w_out_last_o(w_out_last), .dump_active_o(dump_active),
    .bram_addr_o(bram_addr), .bram_data_o(bram_data), .bram_w_en_o(bram_w_en),
    .bram_q_i(bram_q)
  );

  always #5 clk = ~clk;

  // Single-port BRAM: write-or-read, one-cycle registered read.
  always @(posedge clk) begin
    if (bram_w_en) bram_mem[bram_addr] <= bram_data;
    else           bram_q <= bram_mem[bram_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {in_ready, load_done, spike_ready, w_out_valid, w_out_last, dump_active,
                bram_w_en, w_out, w_out_id, bram_addr, bram_data}, 64'd0);
  endtask

  // random_w=0 loads addr^A5; gap_pct is the chance of an idle cycle per write.
  task automatic do_load(input bit random_w, input int kill_at, input int gap_pct,
                         input bit start_kill);
    logic [DATA_W-1:0] w;
    load_start = 1'b1;
    kill       = start_kill;
    #1;
    check("start_spk_rdy", spike_ready, 0);
    tick();
    load_start = 1'b0;
    kill       = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        tick();
        check("ld_gap_wen", bram_w_en, 0);
      end
      check("ld_in_ready", in_ready, 1);
      check("ld_spk_rdy", spike_ready, 0);
      w = random_w ? DATA_W'($urandom) : DATA_W'(i ^ 8'hA5);
      in_valid  = 1'b1;
      in_weight = w;
      kill      = (i == kill_at);
      tick();
      in_valid = 1'b0;
      kill     = 1'b0;
      check("ld_wen", bram_w_en, 1);
      check("ld_addr", bram_addr, i);
      check("ld_data", bram_data, w);
      check("ld_done_early", load_done, 0);
      ref_mem[i] = w;
    end
    tick();
    check("ld_done_pulse", load_done, 1);
    check("ld_in_ready_after", in_ready, 0);
    check("ld_wen_after", bram_w_en, 0);
    tick();
    check("ld_done_single", load_done, 0);
  endtask

  task automatic do_fetch(input logic [ADDR_W-1:0] id, input int hold);
    int lat;
    logic [DATA_W-1:0] exp_w;
    exp_w = ref_mem[id];
    check("ft_spk_rdy", spike_ready, 1);
    spike_valid = 1'b1;
    spike_id    = id;
    tick();
    spike_valid = 1'b0;
    check("ft_spk_rdy_busy", spike_ready, 0);
    lat = 0;
    while (!w_out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("ft_latency", lat, 3);
    check("ft_w_out", w_out, exp_w);
    check("ft_w_out_id", w_out_id, id);
    check("ft_last", w_out_last, 0);
    for (int h = 0; h < hold; h++) begin
      w_out_ready = 1'b0;
      spike_valid = 1'b1;
      spike_id    = ADDR_W'($urandom);
      tick();
      check("hold_valid", w_out_valid, 1);
      check("hold_w_out", w_out, exp_w);
      check("hold_id", w_out_id, id);
      check("hold_spk_rdy", spike_ready, 0);
    end
    spike_valid = 1'b0;
    w_out_ready = 1'b1;
    tick();
    w_out_ready = 1'b0;
    check("ft_valid_clr", w_out_valid, 0);
    check("ft_back_idle", spike_ready, 1);
  endtask

  // Expects a complete dump starting now or within a few cycles.
  task automatic check_dump();
    int cnt;
    int addr;
    cnt = 0;
    while (!dump_active && cnt < 50) begin
      tick();
      cnt++;
    end
    check("dump_start", dump_active, 1);
    addr = 0;
    cnt  = 0;
    while (addr < DEPTH && cnt < 20000) begin
      w_out_ready = $urandom_range(1);
      if (w_out_valid && w_out_ready) begin
        check("dump_id", w_out_id, addr);
        check("dump_data", w_out, ref_mem[addr]);
        check("dump_last", w_out_last, (addr == DEPTH - 1));
        check("dump_active", dump_active, 1);
        check("dump_spk_rdy", spike_ready, 0);
        addr++;
      end
      tick();
      cnt++;
    end
    w_out_ready = 1'b0;
    check("dump_count", addr, DEPTH);
    check("dump_end_active", dump_active, 0);
    check("dump_end_last", w_out_last, 0);
    check("dump_end_valid", w_out_valid, 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    #2;
    check_all_zero("reset_outputs");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("idle_spk_rdy", spike_ready, 1);
    check("idle_in_ready", in_ready, 0);

    // Deterministic load then lookups with and without backpressure.
    do_load(1'b0, -1, 0, 1'b0);
    check("no_dump_after_plain_load", dump_active, 0);
    do_fetch(8'h10, 0);
    check("fetch_10_weight", w_out, 8'hB5);
    do_fetch(8'h7F, 5);
    do_fetch(8'h80, 0);
    do_fetch(8'hFF, 1);

    // Kill after 100 writes: load finishes, then a dump follows.
    do_load(1'b0, 100, 0, 1'b0);
    check_dump();

    // load_start, kill and spike together: load, dump, then the spike.
    spike_valid = 1'b1;
    spike_id    = 8'h42;
    do_load(1'b1, -1, 0, 1'b1);
    check_dump();
    do_fetch(8'h42, 2);

    // Random weights with gaps, random lookups, then a kill from IDLE.
    do_load(1'b1, -1, 30, 1'b0);
    for (int i = 0; i < 20; i++) begin
      do_fetch(ADDR_W'($urandom), int'($urandom_range(4)));
    end
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check_dump();

    // Reset while in the capture state with a kill pending.
    spike_valid = 1'b1;
    spike_id    = 8'h33;
    tick();
    spike_valid = 1'b0;
    kill        = 1'b1;
    tick();
    kill = 1'b0;
    tick();
    check("capt_addr", bram_addr, 8'h33);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_in_capt");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("no_dump_after_rst", dump_active, 0);
    end
    check("rst_idle_spk_rdy", spike_ready, 1);

    // Reset in the middle of a dump.
    kill = 1'b1;
    tick();
    kill = 1'b0;
    n = 0;
    for (int c = 0; c < 2000 && n < 30; c++) begin
      w_out_ready = $urandom_range(1);
      if (w_out_valid && w_out_ready) n++;
      tick();
    end
    w_out_ready = 1'b0;
    check("mid_dump_active", dump_active, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_dump");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("dump_gone_after_rst", dump_active | w_out_valid, 0);
    end
    do_fetch(8'h10, 1);
    do_fetch(8'hC3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
